// File: rtl/piso_pkg.sv
// Shared types and limits for the PISO serializer.
package piso_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int PISO_MAX_WIDTH = 32;
endpackage

// File: rtl/piso_bit_counter.sv
// Clear/enable bit counter that wraps at WIDTH-1 and flags the terminal count.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tc
);
   logic [CW-1:0] count;

   assign tc = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/piso_serializer.sv
// LSB-first parallel-in serial-out serializer with gapless back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy
);
   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sr;
   logic             accept;
   logic             last;
   logic             tc;

   piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .en    (state == SHIFT),
      .tc    (tc)
   );

`ifdef PISO_PARITY_EN
   logic par;

   assign last = (state == PARITY);
   assign dout = ((state == SHIFT) & sr[0]) | ((state == PARITY) & par);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par <= 1'b0;
      end else if (accept) begin
         par <= ^din;
      end
   end
`else
   assign last = (state == SHIFT) & tc;
   assign dout = (state == SHIFT) & sr[0];
`endif

   // Ready is forced low while reset is held, not just after the edge.
   assign din_ready  = ~rst & ((state == IDLE) | last);
   assign accept     = din_valid & din_ready;
   assign dout_valid = (state != IDLE);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nx = state;
      if (accept) begin
         state_nx = SHIFT;
      end else begin
         case (state)
            SHIFT: begin
               if (tc) begin
`ifdef PISO_PARITY_EN
                  state_nx = PARITY;
`else
                  state_nx = IDLE;
`endif
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            sr <= din;
         end else if (state == SHIFT) begin
            sr <= sr >> 1;
         end
      end
   end
endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer against a bit-queue model.
module tb_piso_serializer;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_ready;
   logic         dout;
   logic         dout_valid;
   logic         busy;

   int checks = 0;
   int errors = 0;
   bit q[$];

   piso_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: q holds the frame bits still to appear; q[0] is on the wire now.
   task automatic check_outputs();
      if (q.size() == 0) begin
         check("dout_valid", dout_valid, 0);
         check("dout", dout, 0);
         check("busy", busy, 0);
         check("din_ready", din_ready, 1);
      end else begin
         check("dout_valid", dout_valid, 1);
         check("dout", dout, q[0]);
         check("busy", busy, 1);
         check("din_ready", din_ready, q.size() == 1);
      end
   endtask

   task automatic tick(input logic v, input logic [W-1:0] d);
      bit rdy;
      @(negedge clk);
      check_outputs();
      rdy = (q.size() <= 1);
      din_valid = v;
      din = d;
      if (q.size() != 0) void'(q.pop_front());
      if (v && rdy) begin
         for (int i = 0; i < W; i++) q.push_back(d[i]);
`ifdef PISO_PARITY_EN
         q.push_back(^d);
`endif
      end
   endtask

   initial begin
      #1;
      check("rst_dout_valid", dout_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_din_ready", din_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("post_rst_ready", din_ready, 1);

      // Single frame 0xA5, then drain into idle.
      tick(1, 8'hA5);
      for (int i = 0; i < W + 3; i++) tick(0, 8'h00);

      // Back-to-back 0x01 then 0x80 with valid held high.
      tick(1, 8'h01);
      for (int i = 0; i < W - 1; i++) tick(1, 8'h80);
      tick(1, 8'h80);
      for (int i = 0; i < W + 3; i++) tick(0, 8'h00);

      // Parity-relevant word 0x07.
      tick(1, 8'h07);
      for (int i = 0; i < W + 3; i++) tick(0, 8'h00);

      // Async reset after the third bit of 0xFF.
      tick(1, 8'hFF);
      tick(0, 8'h00);
      tick(0, 8'h00);
      tick(0, 8'h00);
      @(negedge clk);
      check_outputs();
      #2 rst = 1'b1;
      #1;
      check("arst_dout", dout, 0);
      check("arst_dout_valid", dout_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_din_ready", din_ready, 0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1 check("rel_din_ready", din_ready, 1);
      tick(1, 8'h0F);
      for (int i = 0; i < W + 3; i++) tick(0, 8'h00);

      // Random din/din_valid toggling, including mid-frame noise.
      for (int i = 0; i < 600; i++) begin
         tick(1'($urandom_range(0, 1)), 8'($urandom));
      end
      for (int i = 0; i < W + 3; i++) tick(0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got stuck expected finish");
      $fatal(1);
   end
endmodule
